// File: rtl/sobel_matrix_3x3_gen.sv
// 3x3 neighbourhood generator for the Sobel stage: two line buffers plus a
// 3-column shift window, with top/left zero padding and 2-clk latency.
`timescale 1ns/1ps
module sobel_matrix_3x3_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [DATA_W-1:0] per_img_gray,
  output logic [DATA_W-1:0] data11,
  output logic [DATA_W-1:0] data12,
  output logic [DATA_W-1:0] data13,
  output logic [DATA_W-1:0] data21,
  output logic [DATA_W-1:0] data22,
  output logic [DATA_W-1:0] data23,
  output logic [DATA_W-1:0] data31,
  output logic [DATA_W-1:0] data32,
  output logic [DATA_W-1:0] data33,
  output logic              matrix_frame_vsync,
  output logic              matrix_frame_href,
  output logic              matrix_frame_clken,
  output logic              line_overflow
);
  localparam int CW = $clog2(IMG_WIDTH + 1);
  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic              href_d, vsync_d;
  logic              accept, href_rise, href_fall, vs_rise;
  logic [CW-1:0]     col_cnt;
  logic [RW-1:0]     row_cnt, row_eff;
  logic              ovf;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] buf1 [IMG_WIDTH];
  logic [DATA_W-1:0] buf2 [IMG_WIDTH];
  logic [DATA_W-1:0] rd1, rd2;
  logic [DATA_W-1:0] p_d, r1, r2;
  logic [1:0]        vld_pipe, vs_pipe, href_pipe;
  logic [2:0][DATA_W-1:0]      col_in;
  logic [2:0][2:0][DATA_W-1:0] tap;

  assign accept    = per_frame_clken & per_frame_href;
  assign href_rise = per_frame_href & ~href_d;
  assign href_fall = ~per_frame_href & href_d;
  assign vs_rise   = per_frame_vsync & ~vsync_d;
  assign ovf       = (col_cnt == CW'(IMG_WIDTH));
  assign addr      = col_cnt[AW-1:0];
  // A vsync edge in the same cycle as a pixel makes that pixel row 0.
  assign row_eff   = vs_rise ? '0 : row_cnt;
  assign rd1       = buf1[addr];
  assign rd2       = buf2[addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      href_d        <= 1'b0;
      vsync_d       <= 1'b0;
      col_cnt       <= '0;
      row_cnt       <= '0;
      line_overflow <= 1'b0;
    end else begin
      href_d  <= per_frame_href;
      vsync_d <= per_frame_vsync;
      if (href_fall)            col_cnt <= '0;
      else if (accept && !ovf)  col_cnt <= col_cnt + 1'b1;
      if (vs_rise)              row_cnt <= '0;
      else if (href_fall && row_cnt != RW'(IMG_HEIGHT - 1))
                                row_cnt <= row_cnt + 1'b1;
      if (vs_rise)              line_overflow <= 1'b0;
      else if (accept && ovf)   line_overflow <= 1'b1;
    end
  end

  // Read-before-write: buf2 takes the row that buf1 held a line ago.
  always_ff @(posedge clk) begin
    if (accept && !ovf) begin
      buf1[addr] <= per_img_gray;
      buf2[addr] <= rd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_d       <= '0;
      r1        <= '0;
      r2        <= '0;
      vld_pipe  <= '0;
      vs_pipe   <= '0;
      href_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[0], accept};
      vs_pipe   <= {vs_pipe[0], per_frame_vsync};
      href_pipe <= {href_pipe[0], per_frame_href};
      if (accept) begin
        p_d <= per_img_gray;
        r1  <= (ovf || row_eff == '0)       ? '0 : rd1;
        r2  <= (ovf || row_eff < RW'(2))    ? '0 : rd2;
      end
    end
  end

  assign col_in[0] = r2;
  assign col_in[1] = r1;
  assign col_in[2] = p_d;

  // href_rise can never coincide with vld_pipe[0]: that needs href high last cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap <= '0;
    end else if (href_rise) begin
      tap <= '0;
    end else if (vld_pipe[0]) begin
      for (int r = 0; r < 3; r++) begin
        tap[r][0] <= tap[r][1];
        tap[r][1] <= tap[r][2];
        tap[r][2] <= col_in[r];
      end
    end
  end

  assign data11 = tap[0][0];
  assign data12 = tap[0][1];
  assign data13 = tap[0][2];
  assign data21 = tap[1][0];
  assign data22 = tap[1][1];
  assign data23 = tap[1][2];
  assign data31 = tap[2][0];
  assign data32 = tap[2][1];
  assign data33 = tap[2][2];

  assign matrix_frame_vsync = vs_pipe[1];
  assign matrix_frame_href  = href_pipe[1];
  assign matrix_frame_clken = vld_pipe[1];
endmodule

// File: tb/tb_sobel_matrix_3x3_gen.sv
// Directed bench for sobel_matrix_3x3_gen on a 4x4 image: windows, gapped
// strobes, overflow, and reset recovery.
`timescale 1ns/1ps
module tb_sobel_matrix_3x3_gen;
  localparam int W = 4, H = 4, DW = 8;

  logic clk = 1'b0;
  logic rst, vsync, href, clken;
  logic [DW-1:0] gray;
  logic [DW-1:0] data11, data12, data13, data21, data22, data23, data31, data32, data33;
  logic mvs, mhref, mclken, ovf;

  sobel_matrix_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
    .per_img_gray(gray),
    .data11(data11), .data12(data12), .data13(data13),
    .data21(data21), .data22(data22), .data23(data23),
    .data31(data31), .data32(data32), .data33(data33),
    .matrix_frame_vsync(mvs), .matrix_frame_href(mhref), .matrix_frame_clken(mclken),
    .line_overflow(ovf)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [71:0] win;
  logic [71:0] wq[$];
  logic [2:0]  h1 = '0, h2 = '0;
  bit          chk_dly = 1'b0;

  assign win = {data11, data12, data13, data21, data22, data23, data31, data32, data33};

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mclken) wq.push_back(win);
    if (chk_dly) check("dly2", {69'd0, mvs, mhref, mclken}, {69'd0, h2});
    h2 <= h1;
    h1 <= {vsync, href, clken & href};
  end

  function automatic logic [7:0] px(input int base, input int r, input int c);
    if (r < 0 || c < 0) return 8'd0;
    return 8'(base + r * 16 + c);
  endfunction

  function automatic logic [71:0] ew(input int base, input int r, input int c);
    return {px(base, r-2, c-2), px(base, r-2, c-1), px(base, r-2, c),
            px(base, r-1, c-2), px(base, r-1, c-1), px(base, r-1, c),
            px(base, r,   c-2), px(base, r,   c-1), px(base, r,   c)};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic vs_pulse();
    vsync = 1'b1; tick(); tick();
    vsync = 1'b0; tick();
  endtask

  // gap>0: strobe once every gap+1 cycles, and toggle clken outside href.
  task automatic line(input int base, input int r, input int n, input int gap);
    href = 1'b1;
    for (int c = 0; c < n; c++) begin
      for (int g = 0; g < gap; g++) begin clken = 1'b0; gray = 8'hEE; tick(); end
      clken = 1'b1; gray = px(base, r, c); tick();
    end
    clken = 1'b0; href = 1'b0;
    for (int g = 0; g < 3; g++) begin clken = (gap > 0); gray = 8'hEE; tick(); end
    clken = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_win"}, win, 72'd0);
    check({tag, "_ctl"}, {68'd0, mvs, mhref, mclken, ovf}, 72'd0);
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; href = 1'b0; clken = 1'b0; gray = '0;
    tick(); tick();
    check_idle("reset");
    rst = 1'b0; tick();

    // continuous 4x4 frame
    wq.delete(); vs_pulse();
    for (int r = 0; r < H; r++) line(0, r, W, 0);
    repeat (4) tick();
    check("f1_cnt", 72'(wq.size()), 72'd16);
    if (wq.size() == 16) begin
      check("f1_first", wq[0],  72'h00_00_00_00_00_00_00_00_00);
      check("f1_r0end", wq[3],  72'h00_00_00_00_00_00_01_02_03);
      check("f1_r2end", wq[11], 72'h01_02_03_11_12_13_21_22_23);
      check("f1_r3beg", wq[12], 72'h00_00_10_00_00_20_00_00_30);
      for (int i = 0; i < 16; i++) check($sformatf("f1_w%0d", i), wq[i], ew(0, i / 4, i % 4));
    end

    // gapped strobes with delay tracking
    wq.delete(); chk_dly = 1'b1; vs_pulse();
    for (int r = 0; r < H; r++) line(0, r, W, 2);
    repeat (4) tick();
    chk_dly = 1'b0;
    check("f2_cnt", 72'(wq.size()), 72'd16);
    if (wq.size() == 16)
      for (int i = 0; i < 16; i++) check($sformatf("f2_w%0d", i), wq[i], ew(0, i / 4, i % 4));

    // overlong line
    wq.delete(); vs_pulse();
    check("ovf_clr0", 72'(ovf), 72'd0);
    href = 1'b1;
    for (int c = 0; c < 6; c++) begin
      clken = 1'b1; gray = 8'(c); tick();
      if (c == 3) check("ovf_after4", 72'(ovf), 72'd0);
      if (c == 4) check("ovf_after5", 72'(ovf), 72'd1);
    end
    clken = 1'b0; href = 1'b0; tick(); tick(); tick();
    line(0, 1, W, 0);
    repeat (4) tick();
    check("f3_cnt", 72'(wq.size()), 72'd10);
    if (wq.size() == 10) begin
      check("f3_px5", wq[4], 72'h00_00_00_00_00_00_02_03_04);
      check("f3_px6", wq[5], 72'h00_00_00_00_00_00_03_04_05);
      for (int c = 0; c < W; c++) check($sformatf("f3_r1c%0d", c), wq[6 + c], ew(0, 1, c));
    end
    check("ovf_sticky", 72'(ovf), 72'd1);
    vs_pulse();
    check("ovf_vsclr", 72'(ovf), 72'd0);

    // reset mid-row 2, then a fresh frame
    line(0, 0, W, 0); line(0, 1, W, 0);
    href = 1'b1; clken = 1'b1; gray = 8'h20; tick(); gray = 8'h21; tick();
    rst = 1'b1; tick();
    check_idle("rst_mid1");
    tick();
    check_idle("rst_mid2");
    rst = 1'b0; href = 1'b0; clken = 1'b0; tick(); tick(); tick();
    wq.delete(); vs_pulse();
    line(8'h80, 0, W, 0); line(8'h80, 1, W, 0);
    repeat (4) tick();
    check("f5_cnt", 72'(wq.size()), 72'd8);
    if (wq.size() == 8) begin
      check("f5_r1end", wq[7], 72'h00_00_00_81_82_83_91_92_93);
      for (int i = 0; i < 8; i++) check($sformatf("f5_w%0d", i), wq[i], ew(8'h80, i / 4, i % 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
